// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - synchronised, debounced GPIO inputs with sticky edge flags and read-to-clear port
module gpio_in_debounce #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               CNT_W           = 20,
    parameter logic [WIDTH-1:0] INIT            = '0
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    input  logic             rd_en,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] level,
    output logic             irq
);

    // Counter value on which a still-differing sample is accepted as the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SEL_LEVEL = 2'd0;
    localparam logic [1:0] SEL_RISE  = 2'd1;
    localparam logic [1:0] SEL_FALL  = 2'd2;
    localparam logic [1:0] SEL_ANY   = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0] set_rise;
    logic [WIDTH-1:0] set_fall;
    logic [WIDTH-1:0] clr_rise;
    logic [WIDTH-1:0] clr_fall;
    logic [WIDTH-1:0] sel_val;

    // Two-flop synchroniser; only the second stage is allowed to feed logic.
    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: count consecutive samples that disagree with the level,
    // accept the new value on the last count and raise the matching event.
    always_comb begin
        level_d  = level_q;
        set_rise = '0;
        set_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    if (sync2_q[i]) begin
                        set_rise[i] = 1'b1;
                    end else begin
                        set_fall[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Read mux and clear masks; a clear only drops bits that were actually returned.
    always_comb begin
        sel_val  = '0;
        clr_rise = '0;
        clr_fall = '0;
        case (rd_sel)
            SEL_LEVEL: sel_val = level_q;
            SEL_RISE: begin
                sel_val  = rise_q;
                clr_rise = rd_en ? rise_q : '0;
            end
            SEL_FALL: begin
                sel_val  = fall_q;
                clr_fall = rd_en ? fall_q : '0;
            end
            SEL_ANY: begin
                sel_val  = rise_q | fall_q;
                clr_rise = rd_en ? rise_q : '0;
                clr_fall = rd_en ? fall_q : '0;
            end
            default: sel_val = '0;
        endcase
    end

    // Sticky flags: a new event at the same edge as a clear wins, so none is lost.
    always_comb begin
        rise_d     = (rise_q & ~clr_rise) | set_rise;
        fall_d     = (fall_q & ~clr_fall) | set_fall;
        rd_data_d  = rd_en ? sel_val : rd_data_q;
        rd_valid_d = rd_en;
    end

    // State registers; reset discards any count in progress without reporting an edge.
    always_ff @(posedge clk50) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= INIT;
            rise_q     <= '0;
            fall_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Outputs come straight from flops; irq is a plain OR of the flag flops.
    always_comb begin
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        level    = level_q;
        irq      = |(rise_q | fall_q);
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb/tb_gpio_in_debounce.sv - self-checking bench for gpio_in_debounce
module tb_gpio_in_debounce;

    localparam int               WIDTH = 8;
    localparam int               DB    = 4;
    localparam int               CW    = 3;
    localparam logic [WIDTH-1:0] INIT  = '0;

    logic             clk50 = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] pins;
    logic             rd_en;
    logic [1:0]       rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] level;
    logic             irq;

    int checks = 0;
    int errors = 0;

    gpio_in_debounce #(
        .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .INIT(INIT)
    ) dut (
        .clk50(clk50), .rst(rst), .pins(pins), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .irq(irq)
    );

    always #5 clk50 = ~clk50;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pin samples delayed two edges, then a window of the last
    // DB post-reset samples; a bit flips when every sample in it disagrees.
    logic             armed = 1'b0;
    logic [WIDTH-1:0] p1, p2;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_level, m_rise, m_fall, m_rd_data;
    logic             m_rd_valid;

    always @(posedge clk50) begin
        logic [WIDTH-1:0] sv, nr, nf, cr, cf;
        bit all_diff;
        if (rst) begin
            armed      = 1'b1;
            p1         = '0;
            p2         = '0;
            hist.delete();
            m_level    = INIT;
            m_rise     = '0;
            m_fall     = '0;
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
        end else if (armed) begin
            hist.push_back(p2);
            if (hist.size() > DB) void'(hist.pop_front());
            nr = '0;
            nf = '0;
            for (int i = 0; i < WIDTH; i++) begin
                all_diff = (hist.size() == DB);
                foreach (hist[k]) if (hist[k][i] == m_level[i]) all_diff = 0;
                if (all_diff) begin
                    if (hist[DB-1][i]) nr[i] = 1'b1;
                    else               nf[i] = 1'b1;
                end
            end
            cr = '0;
            cf = '0;
            sv = (rd_sel == 2'd0) ? m_level :
                 (rd_sel == 2'd1) ? m_rise  :
                 (rd_sel == 2'd2) ? m_fall  : (m_rise | m_fall);
            if (rd_en) begin
                m_rd_data = sv;
                if (rd_sel == 2'd1 || rd_sel == 2'd3) cr = m_rise;
                if (rd_sel == 2'd2 || rd_sel == 2'd3) cf = m_fall;
            end
            m_rd_valid = rd_en;
            m_rise  = (m_rise & ~cr) | nr;
            m_fall  = (m_fall & ~cf) | nf;
            m_level = m_level ^ (nr | nf);
            p2 = p1;
            p1 = pins;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk50) begin
        if (armed) begin
            chk("m_level", level, m_level);
            chk("m_irq", irq, |(m_rise | m_fall));
            chk("m_rd_valid", rd_valid, m_rd_valid);
            chk("m_rd_data", rd_data, m_rd_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic do_read(input logic [1:0] sel);
        rd_en  = 1'b1;
        rd_sel = sel;
        step(1);
        rd_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pins = '0; rd_en = 1'b0; rd_sel = 2'd0;
        step(2);
        rst = 1'b0;
        chk("reset_level", level, 8'h00);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_irq", irq, 1'b0);
        step(20);
        chk("idle_irq", irq, 1'b0);

        // Clean step on bit 0: level changes on edge 6
        pins = 8'h01;
        step(5);
        chk("step_edge5_level", level, 8'h00);
        step(1);
        chk("step_edge6_level", level, 8'h01);
        chk("step_irq", irq, 1'b1);
        do_read(2'd1);
        chk("rise_read_data", rd_data, 8'h01);
        chk("rise_read_valid", rd_valid, 1'b1);
        do_read(2'd1);
        chk("rise_reread_data", rd_data, 8'h00);
        chk("rise_reread_irq", irq, 1'b0);
        step(1);
        chk("rd_valid_drop", rd_valid, 1'b0);

        // Short glitch on bit 3
        pins = 8'h09;
        step(3);
        pins = 8'h01;
        step(10);
        chk("glitch_level", level, 8'h01);
        chk("glitch_irq", irq, 1'b0);

        // Same-edge race between fall completion and fall read
        pins = 8'h03;
        step(10);
        do_read(2'd1);
        chk("race_setup_rise", rd_data, 8'h02);
        pins = 8'h01;
        step(5);
        do_read(2'd2);
        chk("race_read_data", rd_data, 8'h00);
        chk("race_irq", irq, 1'b1);
        chk("race_level", level, 8'h01);
        do_read(2'd2);
        chk("race_fall_kept", rd_data, 8'h02);
        chk("race_irq_clear", irq, 1'b0);

        // Reset in the middle of a count
        pins = 8'h00;
        step(10);
        do_read(2'd3);
        pins = 8'h01;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        chk("abort_level", level, 8'h00);
        chk("abort_irq", irq, 1'b0);
        step(1);
        chk("abort_relevel", level, 8'h01);
        do_read(2'd1);
        chk("abort_rise", rd_data, 8'h01);

        // All bits rise, upper half falls
        pins = 8'h00; rst = 1'b1; step(2); rst = 1'b0;
        pins = 8'hFF; step(10);
        pins = 8'h0F; step(10);
        do_read(2'd3);
        chk("multi_any", rd_data, 8'hFF);
        pins = 8'h00; rst = 1'b1; step(2); rst = 1'b0;
        pins = 8'hFF; step(10);
        pins = 8'h0F; step(10);
        do_read(2'd1);
        chk("multi_rise", rd_data, 8'hFF);
        do_read(2'd2);
        chk("multi_fall", rd_data, 8'hF0);
        chk("multi_level", level, 8'h0F);

        // Randomised phase: mostly-stable pins with glitches, random reads, rare reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                pins = pins ^ WIDTH'($urandom_range(0, 255));
            rd_en  = ($urandom_range(0, 3) == 0);
            rd_sel = 2'($urandom_range(0, 3));
            rst    = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0; rd_en = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
